// File: rtl/mlp_pkg.sv
// Shared definitions for the time-multiplexed MLP engine: FSM encoding,
// memory-map derivation and the shift/saturate helper used by the MAC.
package mlp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HID,
    ST_OUT,
    ST_DONE
  } state_t;

  function automatic int mlp_depth(input int n_in, input int n_hid, input int n_out);
    return n_hid * (n_in + 1) + n_out * (n_hid + 1);
  endfunction

  function automatic int mlp_hb(input int n_in, input int n_hid);
    return n_hid * (n_in + 1);
  endfunction

  // Product is 2*W bits; four guard bits cover the largest fan-in sum.
  function automatic int mlp_acc_w(input int width);
    return 2 * width + 4;
  endfunction

  // Arithmetic right shift (floor) followed by clamp to a signed width-bit range.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                   input int frac, input int width);
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = acc >>> frac;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (sh > hi) return hi;
    if (sh < lo) return lo;
    return sh;
  endfunction

endpackage

// File: rtl/mlp_mac.sv
// Single multiply-accumulate lane: bias preload, accumulate, then shift,
// saturate and optional ReLU with a one-cycle result strobe.
module mlp_mac
  import mlp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic              last,
  input  logic              relu,
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] res,
  output logic              res_vld
);

  localparam int ACC_W = mlp_acc_w(DATA_W);

  logic signed [2*DATA_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]    bias_p0;
  logic signed [ACC_W-1:0]    sum_p0;
  logic signed [63:0]         sat_p0;
  logic [DATA_W-1:0]          res_p0;
  logic signed [ACC_W-1:0]    acc_p1;

  assign prod_p0 = $signed({{DATA_W{w[DATA_W-1]}}, w}) * $signed({{DATA_W{x[DATA_W-1]}}, x});
  assign bias_p0 = $signed({{(ACC_W-DATA_W){w[DATA_W-1]}}, w}) <<< FRAC;
  assign sum_p0  = acc_p1 + $signed({{(ACC_W-2*DATA_W){prod_p0[2*DATA_W-1]}}, prod_p0});
  assign sat_p0  = sat_shift($signed({{(64-ACC_W){sum_p0[ACC_W-1]}}, sum_p0}), FRAC, DATA_W);
  assign res_p0  = (relu && sat_p0[63]) ? '0 : sat_p0[DATA_W-1:0];

  // ---- stage p0 -> p1: accumulator and finished-neuron register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1  <= '0;
      res     <= '0;
      res_vld <= 1'b0;
    end else begin
      res_vld <= en && last;
      if (en) begin
        acc_p1 <= start ? bias_p0 : sum_p0;
        if (last) res <= res_p0;
      end
    end
  end

endmodule

// File: rtl/mlp_seq_engine.sv
// Two-layer Q-format MLP evaluated one weight word per cycle through a shared
// MAC; weights live in a writable flop memory, results carry an argmax index.
module mlp_seq_engine
  import mlp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int N_IN  = 2,
  parameter int N_HID = 4,
  parameter int N_OUT = 10,
  localparam int DEPTH = mlp_depth(N_IN, N_HID, N_OUT),
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [WIDTH-1:0]       cfg_wdata,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [CW-1:0]          out_class
);

  localparam int HB    = mlp_hb(N_IN, N_HID);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(((N_IN > N_HID) ? N_IN : N_HID) + 1);
  localparam int RW    = $clog2(N_HID + N_OUT + 1);

  state_t                  state;
  logic [CNT_W-1:0]        addr;
  logic [PW-1:0]           pos;
  logic [RW-1:0]           res_cnt;
  logic [WIDTH-1:0]        mem   [DEPTH];
  logic [WIDTH-1:0]        x_reg [N_IN];
  logic [WIDTH-1:0]        hid   [N_HID];
  logic [WIDTH-1:0]        outv  [N_OUT];
  logic signed [WIDTH-1:0] max_val;
  logic [CW-1:0]           cls;

  logic             en_p0, start_p0, last_p0, relu_p0;
  logic [WIDTH-1:0] w_p0, x_p0;
  int               fan_p0, rd_p0;
  logic [WIDTH-1:0] res_p1;
  logic             vld_p1;

  // addr walks base+pos; the bias sits after the weights but is consumed first
  always_comb begin
    fan_p0   = (state == ST_HID) ? N_IN : N_HID;
    start_p0 = (pos == '0);
    last_p0  = (int'(pos) == fan_p0);
    relu_p0  = (state == ST_HID);
    en_p0    = (state == ST_HID) || ((state == ST_OUT) && (int'(addr) < DEPTH));
    rd_p0    = start_p0 ? int'(addr) + fan_p0 : int'(addr) - 1;
    w_p0     = '0;
    if (en_p0 && rd_p0 >= 0 && rd_p0 < DEPTH) w_p0 = mem[AW'(rd_p0)];
    x_p0 = '0;
    if (state == ST_HID) begin
      for (int i = 0; i < N_IN; i++)
        if (int'(pos) == i + 1) x_p0 = x_reg[i];
    end else if (state == ST_OUT) begin
      for (int h = 0; h < N_HID; h++)
        if (int'(pos) == h + 1) x_p0 = hid[h];
    end
  end

  mlp_mac #(
    .DATA_W (WIDTH),
    .FRAC   (FRAC)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en_p0),
    .start   (start_p0),
    .last    (last_p0),
    .relu    (relu_p0),
    .w       (w_p0),
    .x       (x_p0),
    .res     (res_p1),
    .res_vld (vld_p1)
  );

  // ---- stage p1: FSM, config writes, result write-back and argmax
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      addr      <= '0;
      pos       <= '0;
      res_cnt   <= '0;
      max_val   <= '0;
      cls       <= '0;
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
      for (int i = 0; i < N_IN; i++)  x_reg[i] <= '0;
      for (int h = 0; h < N_HID; h++) hid[h] <= '0;
      for (int k = 0; k < N_OUT; k++) outv[k] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_we && int'(cfg_addr) < DEPTH) mem[cfg_addr] <= cfg_wdata;
          if (in_valid) begin
            for (int i = 0; i < N_IN; i++) x_reg[i] <= in_data[i*WIDTH +: WIDTH];
            state    <= ST_HID;
            addr     <= '0;
            pos      <= '0;
            res_cnt  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_HID: begin
          addr <= addr + 1'b1;
          pos  <= last_p0 ? '0 : pos + 1'b1;
          if (int'(addr) == HB - 1) state <= ST_OUT;
        end
        ST_OUT: begin
          // one drain cycle after the last word lets the final result land
          if (int'(addr) < DEPTH) begin
            addr <= addr + 1'b1;
            pos  <= last_p0 ? '0 : pos + 1'b1;
          end else begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (vld_p1) begin
        res_cnt <= res_cnt + 1'b1;
        if (int'(res_cnt) < N_HID) begin
          for (int h = 0; h < N_HID; h++)
            if (int'(res_cnt) == h) hid[h] <= res_p1;
        end else begin
          for (int k = 0; k < N_OUT; k++)
            if (int'(res_cnt) == N_HID + k) outv[k] <= res_p1;
          if (int'(res_cnt) == N_HID || $signed(res_p1) > max_val) begin
            max_val <= $signed(res_p1);
            cls     <= CW'(int'(res_cnt) - N_HID);
          end
        end
      end
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign out_data[k*WIDTH +: WIDTH] = outv[k];
  end
  assign out_class = cls;

endmodule

// File: tb/tb_mlp_seq_engine.sv
// Directed/random bench for mlp_seq_engine against a plain-arithmetic MLP model.
module tb_mlp_seq_engine;

  localparam int W     = 16;
  localparam int FRAC  = 8;
  localparam int N_IN  = 2;
  localparam int N_HID = 4;
  localparam int N_OUT = 10;
  localparam int DEPTH = N_HID * (N_IN + 1) + N_OUT * (N_HID + 1);
  localparam int HB    = N_HID * (N_IN + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(N_OUT);
  localparam int LAT   = DEPTH + 1;
  localparam int DW    = N_OUT * W;

  typedef logic [DW-1:0] dvec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [W-1:0]      cfg_wdata;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN*W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_class;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic signed [W-1:0] wts [DEPTH];
  dvec_t last_data;
  int    last_cls;

  mlp_seq_engine #(
    .WIDTH (W),
    .FRAC  (FRAC),
    .N_IN  (N_IN),
    .N_HID (N_HID),
    .N_OUT (N_OUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_class (out_class)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input dvec_t obs, input dvec_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, dvec_t'(obs), dvec_t'(exp));
  endtask

  function automatic longint sat16(input longint r);
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    return r;
  endfunction

  function automatic logic [W-1:0] rnd(input int r);
    int v;
    v = int'($urandom_range(0, 2 * r)) - r;
    return W'(v);
  endfunction

  // Reference MLP: integer Q8 arithmetic, floor shift, clamp, ReLU on hidden layer.
  function automatic void model(input logic [N_IN*W-1:0] v, output dvec_t od, output int cls);
    longint acc;
    longint hv [N_HID];
    longint ov [N_OUT];
    logic signed [W-1:0] xs;
    od = '0;
    for (int j = 0; j < N_HID; j++) begin
      acc = longint'(wts[j*(N_IN+1)+N_IN]) * (longint'(1) << FRAC);
      for (int i = 0; i < N_IN; i++) begin
        xs = v[i*W +: W];
        acc += longint'(xs) * longint'(wts[j*(N_IN+1)+i]);
      end
      hv[j] = sat16(acc >>> FRAC);
      if (hv[j] < 0) hv[j] = 0;
    end
    for (int k = 0; k < N_OUT; k++) begin
      acc = longint'(wts[HB+k*(N_HID+1)+N_HID]) * (longint'(1) << FRAC);
      for (int h = 0; h < N_HID; h++)
        acc += hv[h] * longint'(wts[HB+k*(N_HID+1)+h]);
      ov[k] = sat16(acc >>> FRAC);
      od[k*W +: W] = ov[k][W-1:0];
    end
    cls = 0;
    for (int k = 1; k < N_OUT; k++)
      if (ov[k] > ov[cls]) cls = k;
  endfunction

  task automatic write_w(input int a, input logic [W-1:0] d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(a);
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    wts[a] = d;
  endtask

  task automatic load_random(input int r);
    for (int a = 0; a < DEPTH; a++) write_w(a, rnd(r));
  endtask

  task automatic send(input logic [N_IN*W-1:0] v);
    @(negedge clk);
    chk1("in_ready_before_send", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input logic [N_IN*W-1:0] v, input string tag);
    dvec_t ed;
    int    ec, lat;
    model(v, ed, ec);
    send(v);
    chk1({tag, "_busy"}, busy, 1'b1);
    chk1({tag, "_in_ready_low"}, in_ready, 1'b0);
    wait_out(lat);
    chk({tag, "_latency"}, dvec_t'(lat), dvec_t'(LAT));
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_class"}, dvec_t'(out_class), dvec_t'(ec));
    last_data = out_data;
    last_cls  = int'(out_class);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk1({tag, "_valid_drop"}, out_valid, 1'b0);
    chk1({tag, "_in_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    dvec_t ed, ed2, snap, sat_vec;
    int    ec, ec2, lat, seen, t1;
    logic [N_IN*W-1:0] v, v2;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int a = 0; a < DEPTH; a++) wts[a] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_class", dvec_t'(out_class), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk1("idle_in_ready", in_ready, 1'b1);
    chk1("idle_out_valid", out_valid, 1'b0);
    chk("idle_out_data", out_data, '0);
    chk("idle_out_class", dvec_t'(out_class), '0);

    // Random moderate weights with a couple of fixed vfr-style words
    load_random(512);
    write_w(0, 16'h04D9);
    write_w(HB + N_HID, 16'hFC1A);
    run({16'h00CD, 16'h0013}, "vfr");
    for (int t = 0; t < 4; t++) run({rnd(1024), rnd(1024)}, "rand_mod");

    load_random(32767);
    for (int t = 0; t < 2; t++) run({rnd(32767), rnd(32767)}, "rand_full");

    // Saturation: hidden all max, outputs weight 1.0, bias 0
    for (int a = 0; a < HB; a++) write_w(a, 16'h7FFF);
    for (int k = 0; k < N_OUT; k++)
      for (int h = 0; h <= N_HID; h++)
        write_w(HB + k*(N_HID+1) + h, (h == N_HID) ? 16'h0000 : 16'h0100);
    run({16'h7FFF, 16'h7FFF}, "sat_pos");
    sat_vec = '0;
    for (int k = 0; k < N_OUT; k++) sat_vec[k*W +: W] = 16'h7FFF;
    chk("sat_pos_const", last_data, sat_vec);
    chk("sat_pos_class", dvec_t'(last_cls), '0);

    for (int j = 0; j < N_HID; j++) write_w(j*(N_IN+1) + N_IN, 16'h8000);
    run({16'h0000, 16'h0000}, "relu_zero");
    chk("relu_zero_const", last_data, '0);
    chk("relu_zero_class", dvec_t'(last_cls), '0);

    // Backpressure with a dropped config write
    load_random(512);
    v = {rnd(1024), rnd(1024)};
    model(v, ed, ec);
    send(v);
    wait_out(lat);
    chk("bp_latency", dvec_t'(lat), dvec_t'(LAT));
    snap = out_data;
    chk("bp_data", snap, ed);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      cfg_we    = (c == 5);
      cfg_addr  = '0;
      cfg_wdata = ~wts[0];
      @(posedge clk);
      #1;
      chk1("bp_valid", out_valid, 1'b1);
      chk("bp_data_stable", out_data, snap);
      chk("bp_class_stable", dvec_t'(out_class), dvec_t'(ec));
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    cfg_we = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    run(v, "bp_rerun");
    chk("bp_rerun_same", last_data, snap);

    // Reset in the middle of an inference clears everything
    send({rnd(1024), rnd(1024)});
    repeat (29) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_in_ready", in_ready, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) wts[a] = '0;
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    chk("midrst_no_valid", dvec_t'(seen), '0);
    run({rnd(1024), rnd(1024)}, "after_rst");
    chk("after_rst_zero", last_data, '0);
    chk("after_rst_class", dvec_t'(last_cls), '0);

    // Back-to-back with in_valid held and out_ready high
    load_random(512);
    v  = {rnd(1024), rnd(1024)};
    v2 = {rnd(1024), rnd(1024)};
    model(v, ed, ec);
    model(v2, ed2, ec2);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = v;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    t1 = cyc;
    in_data = v2;
    chk1("b2b_first_accept", in_ready, 1'b0);
    wait_out(lat);
    chk("b2b_lat1", dvec_t'(cyc - t1), dvec_t'(LAT));
    chk("b2b_data1", out_data, ed);
    chk("b2b_class1", dvec_t'(out_class), dvec_t'(ec));
    @(posedge clk);
    #1;
    chk1("b2b_handshake", out_valid, 1'b0);
    chk1("b2b_idle_gap", in_ready, 1'b1);
    @(posedge clk);
    #1;
    t1 = cyc;
    in_valid = 1'b0;
    chk1("b2b_second_accept", in_ready, 1'b0);
    chk1("b2b_second_busy", busy, 1'b1);
    wait_out(lat);
    chk("b2b_lat2", dvec_t'(cyc - t1), dvec_t'(LAT));
    chk("b2b_data2", out_data, ed2);
    chk("b2b_class2", dvec_t'(out_class), dvec_t'(ec2));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk1("b2b_final_drop", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mlp_seq_engine.md
# mlp_seq_engine

Parametrised, time-multiplexed successor to `vfr_nn`: a 2-layer Q-format MLP (N_IN → N_HID, ReLU → N_OUT, linear) evaluated by a single multiply-accumulate unit, with weights held in an internal writable memory instead of per-weight ports. Inputs arrive and results leave over valid/ready handshakes. Each result carries an argmax class index, so the top level no longer needs a separate comparator. It sits between the feature front-end and the classifier decision logic.

## Interface
- `WIDTH`, 16, signed fixed-point word width (inputs, weights, biases, outputs)
- `FRAC`, 8, fractional bits (Q(WIDTH-FRAC).FRAC)
- `N_IN`, 2, input features
- `N_HID`, 4, hidden neurons
- `N_OUT`, 10, output neurons
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cfg_we`  in  1  weight write strobe
- `cfg_addr`  in  clog2(DEPTH)  weight address; DEPTH = N_HID*(N_IN+1) + N_OUT*(N_HID+1), 62 at defaults
- `cfg_wdata`  in  WIDTH  weight/bias word
- `busy`  out  1  high whenever state ≠ IDLE
- `in_valid`  in  1  input vector valid
- `in_ready`  out  1  high only in IDLE
- `in_data`  in  N_IN*WIDTH  packed inputs, feature 0 in the LSBs
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts the result
- `out_data`  out  N_OUT*WIDTH  packed outputs, neuron 0 in the LSBs
- `out_class`  out  clog2(N_OUT)  index of the largest output

## Operation
- Memory layout, sequential:
  - Hidden neuron j: addresses j*(N_IN+1)+i hold weights w_ji for i < N_IN; the following address holds the bias.
  - Output neuron k: from base HB = N_HID*(N_IN+1), addresses HB + k*(N_HID+1) + h hold weights; the last address of the group holds the bias.
- `cfg_we` takes effect only in IDLE. Writes while busy are dropped silently. Out-of-range addresses are ignored.
- FSM states:
  - IDLE: accept input on `in_valid && in_ready`, latch `in_data`, go to HID.
  - HID: step through the hidden weight region.
  - OUT: step through the output region.
  - DONE: hold `out_valid`; go to IDLE on `out_ready`.
- Neuron evaluation, one memory word per cycle. Each neuron takes fan_in+1 cycles:
  - Cycle 0: acc = bias <<< FRAC.
  - Cycles 1..fan_in: acc += x*w.
  - The neuron result is registered at the end of its last cycle.
- Arithmetic:
  - Product is 2*WIDTH signed.
  - Accumulator is 2*WIDTH+4 bits and never overflows.
  - Result = acc >>> FRAC (arithmetic shift, truncates toward −inf), then saturates to [−2^(WIDTH-1), 2^(WIDTH-1)−1].
  - Hidden results pass through ReLU after saturation (negative → 0). Outputs are not activated.
- Argmax is tracked incrementally as each output completes:
  - Replace the running maximum only on strictly greater; ties go to the lowest index.
  - `out_class` is final when DONE is entered.
- `out_data` and `out_class` are stable for the whole of DONE.

## Timing
- Reset values:
  - Control: `in_ready`=1, `busy`=0, `out_valid`=0.
  - Data: `out_data`=0, `out_class`=0; all weight words and internal registers 0.
- Latency: acceptance at edge T gives `out_valid` rising after edge T+DEPTH+1, i.e. 63 cycles at defaults.
- `in_ready` falls after edge T. The output handshake at edge D returns the FSM to IDLE, so `in_ready`=1 after D.
- The next input is accepted no earlier than edge D+1; there is no overlap of inferences.
- Reset asserted mid-operation: everything returns to reset values immediately, including cleared weights. Any in-flight inference is lost and no `out_valid` is produced.
- A `cfg_we` in the same cycle as an input acceptance is honoured, because the state is still IDLE.

## Structure
- Shared package `mlp_pkg`: FSM state encoding, DEPTH/HB/address-width derivation, accumulator width, and a saturate-and-shift function.
- Sub-module `mlp_mac`: bias load, multiply-accumulate, shift/saturate/optional ReLU, result strobe.
- The top level holds the FSM, address counter, weight memory (flops), hidden/output result registers and argmax.

## Test plan
- Reset → `in_ready`=1, `out_valid`=0, `out_data`=0, `out_class`=0; release `rst_n` and hold `in_valid`=0 for 10 cycles → outputs unchanged.
- Load the vfr_nn weight set (e.g. h1_w1=4.85→0x04D9, bias10=−3.90→0xFC1A truncated) and input (0x0013, 0x00CD) → `out_valid` exactly 63 cycles after acceptance, `out_data` bit-exact to the integer golden model, `out_class`=9.
- Saturation:
  - Stimulus: all hidden weights, biases and inputs 0x7FFF; output weights 0x0100; output biases 0.
  - Required: every output 0x7FFF and `out_class`=0 (tie rule).
  - Negate the hidden biases to 0x8000 → hidden outputs ReLU to 0, every output 0, `out_class`=0.
- Backpressure: `out_ready`=0 for 20 cycles → `out_valid`, `out_data` and `out_class` stable, `in_ready`=0. A `cfg_we` during this window is dropped; a rerun gives an identical result.
- Assert `rst_n`=0 at cycle 30 of an inference → `out_valid` never rises. The next inference with no reload gives all outputs 0 and `out_class`=0.
- Back-to-back with `in_valid` held high and `out_ready`=1 → the second vector is accepted one cycle after the first output handshake; the second result follows 63 cycles later.
